// File: rtl/tone_meter_pkg.sv
// Shared types and defaults for the tone meter: state encoding, counter
// width and parameter defaults used by the filter and the measurement FSM.
package tone_meter_pkg;

    // Width of the half-period counter and of the reported period.
    localparam int CNT_W = 16;

    // Width of the glitch-filter stability counter (holds 0..15).
    localparam int STAB_W = 4;

    // Parameter defaults.
    localparam int               GLITCH_CYCLES_DEF = 2;
    localparam logic [CNT_W-1:0] TIMEOUT_DEF       = 16'd50000;

    typedef logic [CNT_W-1:0] count_t;

    // S_WAIT: no reference edge yet. S_MEASURE: counting since the last edge.
    typedef enum logic [0:0] {
        S_WAIT    = 1'b0,
        S_MEASURE = 1'b1
    } tone_state_e;

    // The counter reads 0 in the cycle after an edge, so the distance
    // between two edges is one more than the count seen at the second one.
    function automatic count_t period_from_count(input count_t count);
        return count + count_t'(1);
    endfunction

endpackage

// File: rtl/tone_filter.sv
// Input conditioning for the tone meter: 2-flop synchronizer followed by a
// glitch filter that accepts a new level only after it has been stable for
// GLITCH_CYCLES consecutive synchronized samples. edge_flag is high for the
// single cycle after the filtered level changes.
module tone_filter
    import tone_meter_pkg::*;
#(
    parameter int GLITCH_CYCLES = GLITCH_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic edge_flag
);

    // The count reaches this value on the last required mismatching sample.
    localparam logic [STAB_W-1:0] LAST_CNT = STAB_W'(GLITCH_CYCLES - 1);

    logic              sync_1;
    logic              sync_2;
    logic [STAB_W-1:0] stable_cnt;

    // Two-stage synchronizer for the asynchronous input.
    always_ff @(negedge clk) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
        end
    end

    // Glitch filter: count consecutive mismatching samples; any sample that
    // agrees with the current level throws the partial count away.
    always_ff @(negedge clk) begin
        if (reset) begin
            level      <= 1'b0;
            stable_cnt <= '0;
            edge_flag  <= 1'b0;
        end else begin
            edge_flag <= 1'b0;
            if (sync_2 != level) begin
                if (stable_cnt == LAST_CNT) begin
                    level      <= sync_2;
                    stable_cnt <= '0;
                    edge_flag  <= 1'b1;
                end else begin
                    stable_cnt <= stable_cnt + STAB_W'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/tone_meter.sv
// Square-wave half-period meter. Every accepted edge of the filtered input
// (rise or fall) closes one measurement; the distance between consecutive
// accepted edges is reported on o_Period. If no edge arrives within TIMEOUT
// cycles the input is declared silent and the next edge only re-establishes
// the reference.
//
// Output protocol: o_Valid is a one-cycle strobe with no back-pressure.
// o_Period is meaningful in the cycle o_Valid is high and holds its value
// until the next strobe (including while o_Silent is set).
module tone_meter
    import tone_meter_pkg::*;
#(
    parameter int               GLITCH_CYCLES = GLITCH_CYCLES_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT       = TIMEOUT_DEF
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             i_In,
    output logic [CNT_W-1:0] o_Period,
    output logic             o_Valid,
    output logic             o_Silent,
    output logic             o_Level,
    output tone_state_e      dbg_state
);

    // Count value at which the silence timeout fires. Because the counter
    // always stops here, it can never wrap.
    localparam count_t LAST_COUNT = TIMEOUT - count_t'(1);

    logic        edge_flag;
    tone_state_e state;
    count_t      counter;

    tone_filter #(
        .GLITCH_CYCLES (GLITCH_CYCLES)
    ) u_filter (
        .clk       (i_Clk),
        .reset     (i_Reset),
        .din       (i_In),
        .level     (o_Level),
        .edge_flag (edge_flag)
    );

    assign dbg_state = state;

    // Measurement FSM: edges close a measurement, the counter bounds the
    // wait, and an edge in the timeout cycle wins over the timeout.
    always_ff @(negedge i_Clk) begin
        if (i_Reset) begin
            state    <= S_WAIT;
            counter  <= '0;
            o_Period <= '0;
            o_Valid  <= 1'b0;
            o_Silent <= 1'b1;
        end else begin
            o_Valid <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (edge_flag) begin
                        counter <= '0;
                        state   <= S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (edge_flag) begin
                        o_Period <= period_from_count(counter);
                        o_Valid  <= 1'b1;
                        o_Silent <= 1'b0;
                        counter  <= '0;
                    end else if (counter == LAST_COUNT) begin
                        o_Silent <= 1'b1;
                        counter  <= '0;
                        state    <= S_WAIT;
                    end else begin
                        counter <= counter + count_t'(1);
                    end
                end
                default: begin
                    counter <= '0;
                    state   <= S_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_meter.sv
// Bench for tone_meter: directed scenarios followed by a randomized segment
// sequence, checked cycle by cycle against a timestamp-based reference model.
module tb_tone_meter;
    import tone_meter_pkg::*;

    localparam int G   = 2;
    localparam int TMO = 1000;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        i_Reset;
    logic        i_In;
    logic [15:0] o_Period;
    logic        o_Valid;
    logic        o_Silent;
    logic        o_Level;
    tone_state_e dbg_state;

    tone_meter #(
        .GLITCH_CYCLES (G),
        .TIMEOUT       (16'(TMO))
    ) dut (
        .i_Clk     (clk),
        .i_Reset   (i_Reset),
        .i_In      (i_In),
        .o_Period  (o_Period),
        .o_Valid   (o_Valid),
        .o_Silent  (o_Silent),
        .o_Level   (o_Level),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // The model works from timestamps: an input value is accepted once it
    // has been seen for G consecutive samples (after the 2-sample sync
    // delay); consecutive accepted changes A1, A2 give a period A2-A1 when
    // A2-A1 <= TMO, otherwise silence is declared TMO+1 cycles after A1.
    int          cyc = 0;
    bit          has_ref = 1'b0;
    int          ref_time = 0;
    bit          edge_prev = 1'b0;
    bit          exp_level = 1'b0;
    bit          exp_valid = 1'b0;
    bit          exp_silent = 1'b1;
    logic [15:0] exp_period = '0;
    bit          samp_q[$];
    logic [15:0] exp_q[$];

    always @(negedge clk) begin
        bit all_diff;
        cyc++;
        if (i_Reset) begin
            has_ref    = 1'b0;
            edge_prev  = 1'b0;
            exp_level  = 1'b0;
            exp_valid  = 1'b0;
            exp_silent = 1'b1;
            exp_period = '0;
            exp_q.delete();
            samp_q.delete();
            repeat (G + 1) samp_q.push_back(1'b0);
        end else begin
            exp_valid = 1'b0;
            if (edge_prev) begin
                if (has_ref) begin
                    exp_period = 16'(cyc - 1 - ref_time);
                    exp_valid  = 1'b1;
                    exp_silent = 1'b0;
                    exp_q.push_back(exp_period);
                end
                has_ref  = 1'b1;
                ref_time = cyc - 1;
            end else if (has_ref && (cyc - ref_time == TMO + 1)) begin
                exp_silent = 1'b1;
                has_ref    = 1'b0;
            end
            all_diff = 1'b1;
            for (int k = 0; k < G; k++)
                if (samp_q[samp_q.size() - 2 - k] == exp_level) all_diff = 1'b0;
            edge_prev = all_diff;
            if (all_diff) exp_level = !exp_level;
            samp_q.push_back(i_In);
            if (samp_q.size() > 32) void'(samp_q.pop_front());
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit          chk_en = 1'b0;
    int          tx_cyc = 0;
    int          last_valid_cyc = 0;
    int          silent_rise_cyc = 0;
    logic        prev_silent = 1'b1;
    logic [15:0] got_q[$];

    always @(posedge clk) begin
        if (chk_en) begin
            check("cyc_valid",  {15'b0, o_Valid},   {15'b0, exp_valid});
            check("cyc_period", o_Period,           exp_period);
            check("cyc_silent", {15'b0, o_Silent},  {15'b0, exp_silent});
            check("cyc_level",  {15'b0, o_Level},   {15'b0, exp_level});
            check("cyc_state",  {15'b0, dbg_state}, {15'b0, has_ref});
            if (o_Valid === 1'b1) begin
                got_q.push_back(o_Period);
                last_valid_cyc = cyc;
                if (exp_q.size() > 0) check("sb_period", o_Period, exp_q.pop_front());
                else                  check("sb_unexpected_valid", {15'b0, o_Valid}, 16'd0);
            end
            if (o_Silent === 1'b1 && prev_silent === 1'b0) silent_rise_cyc = cyc;
            prev_silent = o_Silent;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_seg(input logic lvl, input int n);
        @(posedge clk);
        i_In   = lvl;
        tx_cyc = cyc;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        i_Reset = 1'b1;
        repeat (n) @(posedge clk);
        i_Reset = 1'b0;
    endtask

    task automatic start_scenario();
        @(posedge clk);
        i_In = 1'b0;
        do_reset(2);
        got_q.delete();
        repeat (4) @(posedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_period"}, o_Period,           16'd0);
        check({tag, "_valid"},  {15'b0, o_Valid},   16'd0);
        check({tag, "_silent"}, {15'b0, o_Silent},  16'd1);
        check({tag, "_level"},  {15'b0, o_Level},   16'd0);
        check({tag, "_state"},  {15'b0, dbg_state}, {15'b0, S_WAIT});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic lvl;
        int   r;
        int   len;

        i_Reset = 1'b1;
        i_In    = 1'b0;
        repeat (4) @(posedge clk);
        i_Reset = 1'b0;
        check_reset_values("rst");
        chk_en = 1'b1;

        // 440-cycle square wave: first edge is reference only.
        start_scenario();
        drive_seg(1'b1, 440);
        check("s1_first_edge_no_valid", 16'(got_q.size()), 16'd0);
        check("s1_silent_before_strobe", {15'b0, o_Silent}, 16'd1);
        drive_seg(1'b0, 440);
        check("s1_fall_latency", 16'(last_valid_cyc - tx_cyc), 16'(G + 3));
        check("s1_silent_after_strobe", {15'b0, o_Silent}, 16'd0);
        drive_seg(1'b1, 440);
        check("s1_rise_latency", 16'(last_valid_cyc - tx_cyc), 16'(G + 3));
        drive_seg(1'b0, 440);
        drive_seg(1'b1, 440);
        check("s1_count", 16'(got_q.size()), 16'd4);
        foreach (got_q[i]) check("s1_period", got_q[i], 16'd440);

        // 100-cycle wave with a 1-cycle high glitch in a low phase.
        start_scenario();
        drive_seg(1'b1, 100);
        drive_seg(1'b0, 50);
        drive_seg(1'b1, 1);
        drive_seg(1'b0, 49);
        drive_seg(1'b1, 100);
        drive_seg(1'b0, 100);
        drive_seg(1'b1, 100);
        check("s2_count", 16'(got_q.size()), 16'd4);
        foreach (got_q[i]) check("s2_period", got_q[i], 16'd100);

        // Half-period sweep 10..13.
        start_scenario();
        drive_seg(1'b1, 10);
        drive_seg(1'b0, 11);
        drive_seg(1'b1, 12);
        drive_seg(1'b0, 13);
        drive_seg(1'b1, 20);
        check("s3_count", 16'(got_q.size()), 16'd4);
        foreach (got_q[i]) check("s3_period", got_q[i], 16'(10 + i));

        // Long hold -> silence 1000 cycles after the last strobe; then two
        // edges 50 apart, only the second reports.
        start_scenario();
        drive_seg(1'b1, 100);
        drive_seg(1'b0, 1200);
        check("s4_silent", {15'b0, o_Silent}, 16'd1);
        check("s4_silent_delay", 16'(silent_rise_cyc - last_valid_cyc), 16'd1000);
        check("s4_count_before", 16'(got_q.size()), 16'd1);
        drive_seg(1'b1, 50);
        drive_seg(1'b0, 30);
        check("s4_count_after", 16'(got_q.size()), 16'd2);
        if (got_q.size() == 2) check("s4_period", got_q[1], 16'd50);

        // Reset 300 cycles into a 440-cycle low phase.
        start_scenario();
        drive_seg(1'b1, 440);
        drive_seg(1'b0, 300);
        check("s5_pre_count", 16'(got_q.size()), 16'd1);
        do_reset(1);
        check_reset_values("s5_rst");
        got_q.delete();
        drive_seg(1'b0, 139);
        drive_seg(1'b1, 440);
        drive_seg(1'b0, 440);
        drive_seg(1'b1, 440);
        check("s5_count", 16'(got_q.size()), 16'd2);
        foreach (got_q[i]) check("s5_period", got_q[i], 16'd440);

        // Edge exactly in the timeout cycle.
        start_scenario();
        drive_seg(1'b1, 100);
        drive_seg(1'b0, 1000);
        drive_seg(1'b1, 20);
        check("s6_count", 16'(got_q.size()), 16'd2);
        if (got_q.size() == 2) check("s6_period", got_q[1], 16'd1000);
        check("s6_silent", {15'b0, o_Silent}, 16'd0);

        // Randomized segments: glitches, near-timeout gaps and ordinary gaps.
        start_scenario();
        lvl = 1'b0;
        for (int i = 0; i < 40; i++) begin
            lvl = !lvl;
            r   = $urandom_range(0, 7);
            if (r < 2)       len = $urandom_range(1, 3);
            else if (r == 2) len = $urandom_range(995, 1005);
            else             len = $urandom_range(4, 600);
            if (i == 20) do_reset($urandom_range(1, 3));
            drive_seg(lvl, len);
        end
        repeat (30) @(posedge clk);
        check("sb_drain", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
